// File: rtl/sprite_hit_timer_pkg.sv
// Shared sprite-vector definitions, also used by the sprite image selector and the sprite ROM address logic.
package sprite_hit_timer_pkg;
  localparam int N_SPRITES    = 14;
  localparam int SPRITE_VEC_W = N_SPRITES;

  typedef logic [SPRITE_VEC_W-1:0] sprite_vec_t;
endpackage

// File: rtl/sprite_hold_counter.sv
// One drum zone: hit edge detect, retrigger lockout, frame hold counter and accept pulse.
module sprite_hold_counter #(
  parameter int HOLD_FRAMES    = 30,
  parameter int LOCKOUT_FRAMES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic hit,
  input  logic frame_tick,
  output logic active,
  output logic hit_pulse
);
  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] ARM_MAX  = CNT_W'(HOLD_FRAMES - LOCKOUT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_prev_q, hit_prev_d;
  logic             pulse_q, pulse_d;
  logic             acc;

  // A fresh accept reloads the counter even on a frame tick, so it wins over the decrement.
  always_comb begin
    hit_prev_d = hit;
    acc        = hit & ~hit_prev_q & (cnt_q <= ARM_MAX);
    pulse_d    = acc;
    cnt_d      = cnt_q;
    if (acc) begin
      cnt_d = HOLD_VAL;
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // The edge history keeps tracking hit through reset so a held zone cannot fire on release.
  always_ff @(posedge clk) begin
    hit_prev_q <= hit_prev_d;
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign active    = (cnt_q != '0);
  assign hit_pulse = pulse_q;
endmodule

// File: rtl/sprite_hit_timer.sv
// Turns per-zone drum hits into a frame-aligned registered sprite-active vector.
module sprite_hit_timer
  import sprite_hit_timer_pkg::*;
#(
  parameter int HOLD_FRAMES    = 30,
  parameter int LOCKOUT_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SPRITES-1:0] hit,
  input  logic                 frame_tick,
  output logic [N_SPRITES-1:0] sprites,
  output logic [N_SPRITES-1:0] hit_pulse,
  output logic                 any_active
);
  sprite_vec_t active;
  sprite_vec_t sprites_q, sprites_d;
  logic        any_active_q, any_active_d;

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_zone
    sprite_hold_counter #(
      .HOLD_FRAMES   (HOLD_FRAMES),
      .LOCKOUT_FRAMES(LOCKOUT_FRAMES)
    ) u_zone (
      .clk       (clk),
      .reset     (reset),
      .hit       (hit[i]),
      .frame_tick(frame_tick),
      .active    (active[i]),
      .hit_pulse (hit_pulse[i])
    );
  end

  // Sample the pre-update counts only at frame boundaries so the picture never tears.
  always_comb begin
    sprites_d    = sprites_q;
    any_active_d = any_active_q;
    if (frame_tick) begin
      sprites_d    = active;
      any_active_d = |active;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sprites_q    <= '0;
      any_active_q <= 1'b0;
    end else begin
      sprites_q    <= sprites_d;
      any_active_q <= any_active_d;
    end
  end

  assign sprites    = sprites_q;
  assign any_active = any_active_q;
endmodule

// File: tb/tb_sprite_hit_timer.sv
// Scoreboard bench for sprite_hit_timer: per-cycle model predictions plus directed scenario checks.
module tb_sprite_hit_timer;
  import sprite_hit_timer_pkg::*;

  localparam int HOLD  = 30;
  localparam int LOCK  = 4;
  localparam int FRAME = 100;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 frame_tick;
  logic [N_SPRITES-1:0] hit;
  logic [N_SPRITES-1:0] sprites;
  logic [N_SPRITES-1:0] hit_pulse;
  logic                 any_active;

  always #5 clk = ~clk;

  sprite_hit_timer #(
    .HOLD_FRAMES   (HOLD),
    .LOCKOUT_FRAMES(LOCK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hit       (hit),
    .frame_tick(frame_tick),
    .sprites   (sprites),
    .hit_pulse (hit_pulse),
    .any_active(any_active)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: predicts next-cycle outputs from the inputs seen at each rising edge.
  int                   m_cnt [N_SPRITES];
  logic [N_SPRITES-1:0] m_hit_d;
  logic [N_SPRITES-1:0] e_spr = '0;
  logic [N_SPRITES-1:0] e_pulse;
  logic                 e_any = 1'b0;
  logic                 tick_prev = 1'b0;
  logic [28:0]          sb_q[$];

  always @(posedge clk) begin
    tick_prev = frame_tick && !reset;
    e_pulse   = '0;
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) m_cnt[i] = 0;
      e_spr = '0;
      e_any = 1'b0;
    end else begin
      if (frame_tick) begin
        for (int i = 0; i < N_SPRITES; i++) e_spr[i] = (m_cnt[i] != 0);
        e_any = |e_spr;
      end
      for (int i = 0; i < N_SPRITES; i++) begin
        if (hit[i] && !m_hit_d[i] && m_cnt[i] <= HOLD - LOCK) begin
          m_cnt[i]   = HOLD;
          e_pulse[i] = 1'b1;
        end else if (frame_tick && m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
    m_hit_d = hit;
    sb_q.push_back({e_spr, e_pulse, e_any});
  end

  int          pulse_cnt [N_SPRITES];
  int          lit_cnt   [N_SPRITES];
  logic [28:0] sb_exp;

  initial begin
    for (int i = 0; i < N_SPRITES; i++) begin
      pulse_cnt[i] = 0;
      lit_cnt[i]   = 0;
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_exp = sb_q.pop_front();
      check("sb_outputs", 32'({sprites, hit_pulse, any_active}), 32'(sb_exp));
    end
    for (int i = 0; i < N_SPRITES; i++) begin
      if (hit_pulse[i] === 1'b1) pulse_cnt[i]++;
      if (tick_prev && sprites[i] === 1'b1) lit_cnt[i]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    frame_tick = (cyc % FRAME == 0);
  endtask

  task automatic to_mid();
    while (cyc % FRAME != 50) step();
  endtask

  task automatic to_tick();
    while (cyc % FRAME != 0) step();
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) step();
  endtask

  int bp, bl, bp2;

  initial begin
    reset      = 1'b1;
    hit        = '0;
    frame_tick = 1'b0;
    repeat (5) step();
    check("reset_sprites", 32'(sprites), 32'h0);
    check("reset_pulse", 32'(hit_pulse), 32'h0);
    check("reset_any", 32'(any_active), 32'h0);
    reset = 1'b0;
    step();

    // Single hit on zone 0
    to_mid();
    bp = pulse_cnt[0]; bl = lit_cnt[0];
    hit[0] = 1'b1;
    step();
    check("t1_pulse_hi", 32'(hit_pulse), 32'h1);
    step();
    check("t1_pulse_lo", 32'(hit_pulse), 32'h0);
    check("t1_pre_tick", 32'(sprites), 32'h0);
    repeat (3) step();
    hit[0] = 1'b0;
    to_tick();
    step();
    check("t1_lit", 32'(sprites), 32'h1);
    check("t1_any", 32'(any_active), 32'h1);
    frames(35);
    check("t1_pulses", 32'(pulse_cnt[0] - bp), 32'd1);
    check("t1_frames", 32'(lit_cnt[0] - bl), 32'd30);
    check("t1_clear", 32'(any_active), 32'h0);

    // Level held on zone 3
    to_mid();
    bp = pulse_cnt[3]; bl = lit_cnt[3];
    hit[3] = 1'b1;
    frames(35);
    check("t2_clear_held", 32'(sprites[3]), 32'h0);
    frames(15);
    hit[3] = 1'b0;
    frames(2);
    check("t2_pulses", 32'(pulse_cnt[3] - bp), 32'd1);
    check("t2_frames", 32'(lit_cnt[3] - bl), 32'd30);

    // Lockout on zone 5
    to_mid();
    bp = pulse_cnt[5]; bl = lit_cnt[5];
    hit[5] = 1'b1;
    repeat (5) step();
    hit[5] = 1'b0;
    repeat (195) step();
    hit[5] = 1'b1;
    step();
    check("t3_locked_nopulse", 32'(hit_pulse[5]), 32'h0);
    repeat (4) step();
    hit[5] = 1'b0;
    repeat (395) step();
    hit[5] = 1'b1;
    step();
    check("t3_rearm_pulse", 32'(hit_pulse[5]), 32'h1);
    repeat (4) step();
    hit[5] = 1'b0;
    frames(40);
    check("t3_pulses", 32'(pulse_cnt[5] - bp), 32'd2);
    check("t3_frames", 32'(lit_cnt[5] - bl), 32'd36);

    // Edge coincident with frame_tick on zone 13
    to_tick();
    bp = pulse_cnt[13]; bl = lit_cnt[13];
    hit[13] = 1'b1;
    step();
    check("t4_same_tick", 32'(sprites[13]), 32'h0);
    repeat (4) step();
    hit[13] = 1'b0;
    to_tick();
    step();
    check("t4_next_tick", 32'(sprites[13]), 32'h1);
    frames(35);
    check("t4_pulses", 32'(pulse_cnt[13] - bp), 32'd1);
    check("t4_frames", 32'(lit_cnt[13] - bl), 32'd30);

    // Simultaneous edges on zones 1, 7, 13
    to_mid();
    bl = lit_cnt[7];
    hit = 14'h2082;
    step();
    check("t5_pulses", 32'(hit_pulse), 32'h2082);
    repeat (4) step();
    hit = '0;
    to_tick();
    step();
    check("t5_sprites", 32'(sprites), 32'h2082);
    check("t5_any", 32'(any_active), 32'h1);
    frames(31);
    check("t5_clear", 32'(sprites), 32'h0);
    check("t5_frames", 32'(lit_cnt[7] - bl), 32'd30);

    // Reset mid-hold with hits held across release
    to_mid();
    hit[0] = 1'b1;
    hit[2] = 1'b1;
    frames(3);
    check("t6_lit_before", 32'(sprites), 32'h5);
    reset = 1'b1;
    step();
    check("t6_reset_sprites", 32'(sprites), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    bp  = pulse_cnt[0];
    bp2 = pulse_cnt[2];
    step();
    check("t6_after_any", 32'(any_active), 32'h0);
    frames(3);
    check("t6_no_pulse0", 32'(pulse_cnt[0] - bp), 32'd0);
    check("t6_no_pulse2", 32'(pulse_cnt[2] - bp2), 32'd0);
    check("t6_sprites", 32'(sprites), 32'h0);
    hit = '0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
